carrier_mixer: RTL
==================

Name: carrier_mixer

Overview:
- Pipelined complex down-conversion mixer. Sits directly downstream of the NCO cos/sin splitter.
- Multiplies a real signed ADC sample stream by the NCO carrier: I = x·cos, Q = −x·sin.
- Each product is rounded and saturated to O_WIDTH.
- Feeds the baseband filter/decimator. Valid-only streaming with no backpressure; one output per qualified input.

Parameters:
- D_WIDTH, 12, signed input sample width.
- C_WIDTH, 16, signed carrier width (Q1.(C_WIDTH−1)), matches NCO_cos/NCO_sin.
- O_WIDTH, 16, signed output width for I and Q.
- SHIFT, 11, right shift applied to the D_WIDTH+C_WIDTH product before rounding. Default = C_WIDTH−1−(O_WIDTH−D_WIDTH).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous active-high reset.
- din  in  D_WIDTH  signed ADC sample.
- din_valid  in  1  sample qualifier.
- nco_cos  in  C_WIDTH  signed carrier cosine.
- nco_sin  in  C_WIDTH  signed carrier sine.
- nco_valid  in  1  carrier qualifier (NCO tvalid).
- sat_clear  in  1  synchronous clear of sat_flag.
- i_out  out  O_WIDTH  signed in-phase result.
- q_out  out  O_WIDTH  signed quadrature result.
- out_valid  out  1  result qualifier.
- sat_flag  out  1  sticky: at least one saturation since last clear.

Behaviour:
- Reset is asynchronous, active-high, on clk/rst as already decided. While rst=1:
  - all pipeline registers are 0, including i_out, q_out, out_valid and sat_flag;
  - stage valids are 0.
  - On release, the first out_valid can occur no earlier than 3 cycles after the first qualified input.
- Qualification: an input is accepted on a rising edge when din_valid & nco_valid. Otherwise a bubble enters the pipeline.
- Pipeline: fixed latency 3 cycles, input edge to out_valid.
  - S1: register din, nco_cos, nco_sin and v1.
  - S2: register signed products p_i = x·cos and p_s = x·sin (D_WIDTH+C_WIDTH bits each) and v2.
  - S3: round, shift, negate Q, saturate; register outputs and out_valid = v2.
- Stage data registers load only when that stage's incoming valid is 1. Otherwise they hold. i_out/q_out therefore hold their last value while out_valid=0.
- Valids always advance every cycle (no stall).
- Arithmetic:
  - r = (p + 2^(SHIFT−1)) >>> SHIFT, i.e. round half toward +inf, using a width with no intermediate overflow.
  - I = r_i; Q = −r_s, computed at full width before saturation.
  - Saturation clamps to [−2^(O_WIDTH−1), 2^(O_WIDTH−1)−1].
  - Only the product (−2^(D_WIDTH−1))·(−2^(C_WIDTH−1)) can exceed range at default widths. It must clamp to +max on I, and on Q must yield −2^(O_WIDTH−1) without clamping.
- sat_flag:
  - Set in S3 when a valid result on either I or Q clamps.
  - Cleared by sat_clear on a rising edge.
  - If set and clear coincide, set wins.
- Back-to-back valid inputs produce back-to-back outputs at full rate. Bubbles are preserved in position.
- Reset mid-stream: in-flight samples are discarded and no out_valid is produced for them.
- Parameter legality: SHIFT ≥ 1, checked at elaboration.

Decomposition:
- Shared package holds:
  - the sat_round helper, as a function with widths passed as parameters;
  - width constants D_WIDTH_DEF, C_WIDTH_DEF, O_WIDTH_DEF, SHIFT_DEF, shared with NCO_cos_sin instantiation.
- One natural sub-module: mix_round_sat, a single-rail S3 round/negate/saturate stage, instanced twice (I with negate=0, Q with negate=1). It exports a per-rail saturation pulse.
- Multipliers are inferred in the top level for DSP mapping.

Test Plan:
- din=2047, cos=32767, sin=0, both valid one cycle → 3 cycles later out_valid pulse, i_out=32751, q_out=0, sat_flag=0.
- din=1000, cos=0, sin=16384 → i_out=0, q_out=−8000.
- din=−2048, cos=−32768, sin=−32768 → i_out=32767 (clamped), q_out=−32768, sat_flag=1. Then sat_clear → sat_flag=0. Then sat_clear and a saturating sample coincident at S3 → sat_flag stays 1.
- Stream din=1,2,3,… with cos=16384 continuously valid, with nco_valid low on every 4th cycle → out_valid pattern equals the input-qualifier pattern delayed 3 cycles. Outputs hold during bubbles, and each value equals round(din·16384/2048) = 8·din.
- Assert rst mid-stream with 2 samples in flight → outputs and out_valid go 0 immediately (asynchronous). After release, no spurious out_valid occurs until 3 cycles after the next qualified input.
- Random 10k samples versus a reference model using the rounding and saturation rule → bit-exact I/Q match. sat_flag agrees with the model.

Source files
------------

// File: rtl/carrier_mixer_pkg.sv
// Shared widths and the round/negate/saturate helper for the carrier mixer.
package carrier_mixer_pkg;

    // Default widths, kept identical to the NCO cos/sin splitter instance.
    localparam int D_WIDTH_DEF = 12;
    localparam int C_WIDTH_DEF = 16;
    localparam int O_WIDTH_DEF = 16;
    localparam int SHIFT_DEF   = C_WIDTH_DEF - 1 - (O_WIDTH_DEF - D_WIDTH_DEF);

    // Working width for the helper; any product up to 62 bits fits without overflow.
    localparam int CALC_W = 64;

    typedef struct packed {
        logic                     sat;
        logic signed [CALC_W-1:0] value;
    } sat_round_t;

    // Round half toward +inf after an arithmetic right shift, optionally
    // negate, then clamp into a signed o_width range. The value field holds the
    // clamped result sign-extended to CALC_W bits.
    function automatic sat_round_t sat_round(
        input logic signed [CALC_W-1:0] prod,
        input int unsigned              shift,
        input int unsigned              o_width,
        input logic                     negate
    );
        logic signed [CALC_W-1:0] w_half;
        logic signed [CALC_W-1:0] w_rnd;
        logic signed [CALC_W-1:0] w_val;
        logic signed [CALC_W-1:0] w_max;
        logic signed [CALC_W-1:0] w_min;
        sat_round_t               w_res;
        w_half = 64'sd1 <<< (shift - 32'd1);
        w_rnd  = (prod + w_half) >>> shift;
        if (negate) begin
            w_val = -w_rnd;
        end else begin
            w_val = w_rnd;
        end
        w_max = (64'sd1 <<< (o_width - 32'd1)) - 64'sd1;
        w_min = -(64'sd1 <<< (o_width - 32'd1));
        if (w_val > w_max) begin
            w_res.sat   = 1'b1;
            w_res.value = w_max;
        end else if (w_val < w_min) begin
            w_res.sat   = 1'b1;
            w_res.value = w_min;
        end else begin
            w_res.sat   = 1'b0;
            w_res.value = w_val;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/carrier_mixer_round_sat.sv
// Single-rail output stage: round, optionally negate, saturate and register.
// o_sat is a same-cycle pulse so the parent can update its sticky flag on the
// same edge that loads o_data.
module mix_round_sat
    import carrier_mixer_pkg::*;
#(
    parameter int P_WIDTH = D_WIDTH_DEF + C_WIDTH_DEF,
    parameter int O_WIDTH = O_WIDTH_DEF,
    parameter int SHIFT   = SHIFT_DEF,
    parameter bit NEGATE  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic signed [P_WIDTH-1:0] i_prod,
    output logic signed [O_WIDTH-1:0] o_data,
    output logic                      o_sat
);

    logic signed [CALC_W-1:0]  w_prod_ext;
    sat_round_t                w_res;
    logic                      w_unused_hi;
    logic signed [O_WIDTH-1:0] r_data;

    assign w_prod_ext = CALC_W'(i_prod);

    // Rounded/saturated value for the product currently presented.
    always_comb begin
        w_res = sat_round(w_prod_ext, int'(SHIFT), int'(O_WIDTH), NEGATE);
    end

    // Upper bits are only sign extension of the clamped result.
    assign w_unused_hi = ^w_res.value[CALC_W-1:O_WIDTH];
    assign o_sat       = i_valid & w_res.sat;

    // Output register loads only for a valid product; otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_valid) begin
            r_data <= w_res.value[O_WIDTH-1:0];
        end else begin
            r_data <= r_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/carrier_mixer.sv
// Pipelined complex down-conversion mixer: I = x*cos, Q = -x*sin, each rounded
// and saturated to O_WIDTH. Three register stages, valid-only streaming.
module carrier_mixer
    import carrier_mixer_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int C_WIDTH = C_WIDTH_DEF,
    parameter int O_WIDTH = O_WIDTH_DEF,
    parameter int SHIFT   = SHIFT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [D_WIDTH-1:0] din,
    input  logic                      din_valid,
    input  logic signed [C_WIDTH-1:0] nco_cos,
    input  logic signed [C_WIDTH-1:0] nco_sin,
    input  logic                      nco_valid,
    input  logic                      sat_clear,
    output logic signed [O_WIDTH-1:0] i_out,
    output logic signed [O_WIDTH-1:0] q_out,
    output logic                      out_valid,
    output logic                      sat_flag
);

    localparam int P_WIDTH = D_WIDTH + C_WIDTH;

    if (SHIFT < 1) begin : g_bad_shift
        $error("carrier_mixer: SHIFT must be at least 1");
    end

    logic                      w_accept;
    logic                      w_sat_i;
    logic                      w_sat_q;

    logic signed [D_WIDTH-1:0] r_din;
    logic signed [C_WIDTH-1:0] r_cos;
    logic signed [C_WIDTH-1:0] r_sin;
    logic                      r_v1;
    logic signed [P_WIDTH-1:0] r_p_i;
    logic signed [P_WIDTH-1:0] r_p_s;
    logic                      r_v2;
    logic                      r_out_valid;
    logic                      r_sat_flag;

    assign w_accept = din_valid & nco_valid;

    // S1: capture a sample/carrier pair when both sides are qualified.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din <= '0;
            r_cos <= '0;
            r_sin <= '0;
            r_v1  <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_din <= din;
                r_cos <= nco_cos;
                r_sin <= nco_sin;
            end else begin
                r_din <= r_din;
                r_cos <= r_cos;
                r_sin <= r_sin;
            end
        end
    end

    // S2: full-width signed products, left here so they map onto DSP blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_i <= '0;
            r_p_s <= '0;
            r_v2  <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_p_i <= P_WIDTH'(r_din) * P_WIDTH'(r_cos);
                r_p_s <= P_WIDTH'(r_din) * P_WIDTH'(r_sin);
            end else begin
                r_p_i <= r_p_i;
                r_p_s <= r_p_s;
            end
        end
    end

    // S3: per-rail round/saturate; Q rail carries the negation.
    mix_round_sat #(
        .P_WIDTH (P_WIDTH),
        .O_WIDTH (O_WIDTH),
        .SHIFT   (SHIFT),
        .NEGATE  (1'b0)
    ) u_rail_i (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_v2),
        .i_prod  (r_p_i),
        .o_data  (i_out),
        .o_sat   (w_sat_i)
    );

    mix_round_sat #(
        .P_WIDTH (P_WIDTH),
        .O_WIDTH (O_WIDTH),
        .SHIFT   (SHIFT),
        .NEGATE  (1'b1)
    ) u_rail_q (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_v2),
        .i_prod  (r_p_s),
        .o_data  (q_out),
        .o_sat   (w_sat_q)
    );

    // S3 valid and sticky saturation flag; a new saturation beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sat_flag  <= 1'b0;
        end else begin
            r_out_valid <= r_v2;
            if (w_sat_i | w_sat_q) begin
                r_sat_flag <= 1'b1;
            end else if (sat_clear) begin
                r_sat_flag <= 1'b0;
            end else begin
                r_sat_flag <= r_sat_flag;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sat_flag  = r_sat_flag;

endmodule
